// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digit counter width: $clog2(n), never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Valid/ready operand and result bundle for serial_sub.
interface serial_sub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/serial_sub_digit.sv
// Combinational DIGIT-bit borrow-ripple subtract slice (module sub_digit).
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  // Ripple the borrow from LSB to MSB of the digit.
  always_comb begin
    logic c;
    c = bin;
    d = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = a[i] ^ b[i] ^ c;
      c    = (~a[i] & b[i]) | (~a[i] & c) | (b[i] & c);
    end
    bout = c;
  end

endmodule

// File: rtl/serial_sub.sv
// Digit-serial a - b - bin over WIDTH bits, DIGIT bits per clock, valid/ready on both sides.
// Optional build macro SERIAL_SUB_SAT_EN: unsigned saturation of diff to 0 on borrow-out.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic         clk,
  input logic         rst,
  serial_sub_if.slave bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % DIGIT != 0) || (DIGIT < 1) || (DIGIT > WIDTH)) begin : g_bad_cfg
    $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic [DIGIT-1:0] a_dig, b_dig, d_dig;
  logic             dig_bout;

  assign a_dig = a_q[int'(cnt_q) * DIGIT +: DIGIT];
  assign b_dig = b_q[int'(cnt_q) * DIGIT +: DIGIT];

  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .bin  (borrow_q),
    .d    (d_dig),
    .bout (dig_bout)
  );

  // Next-state and datapath update; result flags settle on the last digit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          cnt_d    = {CW{1'b0}};
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        diff_d[int'(cnt_q) * DIGIT +: DIGIT] = d_dig;
        borrow_d = dig_bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = dig_bout;
          // The top digit of the raw result holds its sign bit.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_dig[DIGIT-1] != a_q[WIDTH-1]);
`ifdef SERIAL_SUB_SAT_EN
          if (dig_bout) begin
            diff_d = {WIDTH{1'b0}};
          end else begin
            diff_d = diff_d;
          end
`endif
          zero_d  = (diff_d == {WIDTH{1'b0}});
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
